hack_screen_scanout: RTL and testbench

HACK_SCREEN_SCANOUT -- requirements
Module: hack_screen_scanout

---
 rtl/hack_screen_scanout.sv | 161 ++++++++++++++++
 tb/tb_hack_screen_scanout.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_screen_scanout.sv
// Hack 512x256 monochrome screen scanout: prefetches one row of 32 words per
// line into a 2-word FIFO and serialises them onto an external timing raster.
//
// state   | meaning
// IDLE    | no read outstanding; may issue the next word fetch
// REQ     | read outstanding for the current line; ack pushes the word
// DISCARD | read outstanding from a previous line; ack drops the word
module hack_screen_scanout #(
  parameter int H_OFFSET   = 64,
  parameter int V_OFFSET   = 112,
  parameter int BORDER_PIX = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_active,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic        o_rd_req,
  output logic [12:0] o_rd_addr,
  input  logic        i_rd_ack,
  input  logic [15:0] i_rd_data,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_pixel,
  output logic        o_underrun
);

  localparam logic [10:0] X_LO   = 11'(H_OFFSET);
  localparam logic [10:0] X_HI   = 11'(H_OFFSET + 512);
  localparam logic [10:0] Y_LO   = 11'(V_OFFSET);
  localparam logic [10:0] Y_HI   = 11'(V_OFFSET + 256);
  localparam logic        BORDER = (BORDER_PIX != 0);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

  fetch_state_t state;
  logic [15:0]  fifo_q [2];
  logic [1:0]   fifo_cnt;
  logic [5:0]   word_cnt;
  logic [7:0]   row;
  logic         fetch_en;

  logic         in_rows;
  logic         in_win;
  logic         line_start;
  logic         push;
  logic         pop;
  logic         issue;
  logic [3:0]   wx;
  logic [7:0]   wy;

  always_comb begin
    in_rows    = ({1'b0, i_y} >= Y_LO) && ({1'b0, i_y} < Y_HI);
    in_win     = i_active && in_rows && ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI);
    wx         = i_x[3:0] - X_LO[3:0];
    wy         = i_y[7:0] - Y_LO[7:0];
    line_start = i_pix_stb && i_active && (i_x == 10'd0);
    // A word acked on the line-start cycle belongs to the old line and is dropped.
    push       = (state == REQ) && i_rd_ack && !line_start;
    pop        = i_pix_stb && in_win && (fifo_cnt != 2'd0) && (wx == 4'hF);
    issue      = (state == IDLE) && fetch_en && !line_start && !word_cnt[5] &&
                 (fifo_cnt < 2'd2);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_rd_req   <= 1'b0;
      o_rd_addr  <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_cnt   <= '0;
      word_cnt   <= '0;
      row        <= '0;
      fetch_en   <= 1'b0;
      o_hs       <= 1'b1;
      o_vs       <= 1'b1;
      o_de       <= 1'b0;
      o_pixel    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= REQ;
            o_rd_req  <= 1'b1;
            o_rd_addr <= {row, word_cnt[4:0]};
          end
        end
        REQ: begin
          if (i_rd_ack) begin
            state    <= IDLE;
            o_rd_req <= 1'b0;
          end else if (line_start) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (i_rd_ack) begin
            state    <= IDLE;
            o_rd_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          o_rd_req <= 1'b0;
        end
      endcase

      if (line_start) begin
        fifo_cnt <= '0;
        word_cnt <= '0;
        fetch_en <= in_rows;
        if (in_rows) row <= wy;
      end else begin
        if (push) word_cnt <= word_cnt + 6'd1;
        case ({push, pop})
          2'b10: begin
            fifo_q[fifo_cnt[0]] <= i_rd_data;
            fifo_cnt            <= fifo_cnt + 2'd1;
          end
          2'b01: begin
            fifo_q[0] <= fifo_q[1];
            fifo_cnt  <= fifo_cnt - 2'd1;
          end
          2'b11: begin
            if (fifo_cnt == 2'd1) begin
              fifo_q[0] <= i_rd_data;
            end else begin
              fifo_q[0] <= fifo_q[1];
              fifo_q[1] <= i_rd_data;
            end
          end
          default: ;
        endcase
      end

      if (i_pix_stb) begin
        o_hs <= i_hs;
        o_vs <= i_vs;
        o_de <= i_active;
        if (!i_active) begin
          o_pixel <= 1'b0;
        end else if (!in_win) begin
          o_pixel <= BORDER;
        end else if (fifo_cnt != 2'd0) begin
          o_pixel <= fifo_q[0][wx];
        end else begin
          // Starved pixel: flagged only; later words stay aligned by count, not position.
          o_pixel    <= 1'b0;
          o_underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Scoreboard bench for hack_screen_scanout: drives an 800x525 raster, models
// the video RAM with a programmable ack delay and checks each delayed pixel.
module tb_hack_screen_scanout;

  logic        clk;
  logic        i_rst;
  logic        i_pix_stb;
  logic        i_hs;
  logic        i_vs;
  logic        i_active;
  logic [9:0]  i_x;
  logic [9:0]  i_y;
  logic        o_rd_req;
  logic [12:0] o_rd_addr;
  logic        i_rd_ack;
  logic [15:0] i_rd_data;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic        o_pixel;
  logic        o_underrun;

  hack_screen_scanout dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_pix_stb  (i_pix_stb),
    .i_hs       (i_hs),
    .i_vs       (i_vs),
    .i_active   (i_active),
    .i_x        (i_x),
    .i_y        (i_y),
    .o_rd_req   (o_rd_req),
    .o_rd_addr  (o_rd_addr),
    .i_rd_ack   (i_rd_ack),
    .i_rd_data  (i_rd_data),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_de       (o_de),
    .o_pixel    (o_pixel),
    .o_underrun (o_underrun)
  );

  typedef struct {
    bit hs;
    bit vs;
    bit de;
    bit pix;
    bit chk_pix;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ram [8192];
  int          req_log[$];
  int          ack_delay;
  int          div;
  int          wait_cnt;
  bit          req_seen;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Video RAM: acks ack_delay cycles after the request rises, logs each request.
  always @(negedge clk) begin
    if (o_rd_req) begin
      if (!req_seen) begin
        req_log.push_back(int'(o_rd_addr));
        req_seen = 1'b1;
        wait_cnt = 0;
      end
      if (wait_cnt >= ack_delay && !i_rd_ack) begin
        i_rd_ack  = 1'b1;
        i_rd_data = ram[o_rd_addr];
      end else begin
        i_rd_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      req_seen = 1'b0;
      i_rd_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit act_of(int x, int y);
    return (x < 640) && (y < 480);
  endfunction

  function automatic bit hs_of(int x);
    return !(x >= 656 && x < 752);
  endfunction

  function automatic bit vs_of(int y);
    return !(y >= 490 && y < 492);
  endfunction

  function automatic bit pix_of(int x, int y);
    logic [15:0] w;
    if (!act_of(x, y)) return 1'b0;
    if (x >= 64 && x < 576 && y >= 112 && y < 368) begin
      w = ram[(y - 112) * 32 + (x - 64) / 16];
      return w[(x - 64) % 16];
    end
    return 1'b0;
  endfunction

  task automatic pix(input int x, input int y, input bit chk);
    exp_t e;
    @(negedge clk);
    i_pix_stb = 1'b1;
    i_x       = 10'(x);
    i_y       = 10'(y);
    i_active  = act_of(x, y);
    i_hs      = hs_of(x);
    i_vs      = vs_of(y);
    e.hs      = hs_of(x);
    e.vs      = vs_of(y);
    e.de      = act_of(x, y);
    e.pix     = pix_of(x, y);
    e.chk_pix = chk;
    sb.push_back(e);
    @(negedge clk);
    i_pix_stb = 1'b0;
    e = sb.pop_front();
    check_val($sformatf("hs x%0d y%0d", x, y), o_hs, e.hs);
    check_val($sformatf("vs x%0d y%0d", x, y), o_vs, e.vs);
    check_val($sformatf("de x%0d y%0d", x, y), o_de, e.de);
    if (e.chk_pix) check_val($sformatf("pixel x%0d y%0d", x, y), o_pixel, e.pix);
    if (div > 1) begin
      repeat (div - 1) @(negedge clk);
      check_val($sformatf("hold_de x%0d y%0d", x, y), o_de, e.de);
      if (e.chk_pix) check_val($sformatf("hold_pixel x%0d y%0d", x, y), o_pixel, e.pix);
    end
  endtask

  task automatic line(input int y);
    req_log.delete();
    for (int x = 0; x < 800; x++) pix(x, y, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst     = 1'b1;
    i_pix_stb = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic fill_ram(input logic [15:0] v);
    foreach (ram[i]) ram[i] = v;
  endtask

  function automatic int first_req();
    return (req_log.size() > 0) ? req_log[0] : -1;
  endfunction

  function automatic int last_req();
    return (req_log.size() > 0) ? req_log[req_log.size() - 1] : -1;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    div       = 1;
    ack_delay = 1;
    wait_cnt  = 0;
    req_seen  = 1'b0;
    i_rst     = 1'b1;
    i_pix_stb = 1'b0;
    i_hs      = 1'b1;
    i_vs      = 1'b1;
    i_active  = 1'b0;
    i_x       = '0;
    i_y       = '0;
    i_rd_ack  = 1'b0;
    i_rd_data = '0;
    fill_ram(16'h0000);

    do_reset();
    check_val("reset_rd_req", o_rd_req, 0);
    check_val("reset_hs", o_hs, 1);
    check_val("reset_vs", o_vs, 1);
    check_val("reset_de", o_de, 0);
    check_val("reset_pixel", o_pixel, 0);
    check_val("reset_underrun", o_underrun, 0);

    // First window line, single set pixel at the top-left corner.
    ram[0] = 16'h0001;
    line(112);
    check_val("l112_req_count", req_log.size(), 32);
    check_val("l112_first_addr", first_req(), 0);
    check_val("l112_underrun", o_underrun, 0);

    // Last window line: bottom-right pixel at the top of the address space.
    do_reset();
    fill_ram(16'h0000);
    ram[8191] = 16'h8000;
    line(367);
    check_val("l367_req_count", req_log.size(), 32);
    check_val("l367_last_addr", last_req(), 8191);
    line(368);
    check_val("l368_req_count", req_log.size(), 0);
    check_val("l367_underrun", o_underrun, 0);

    // Slow memory with a slow strobe: starved pixels read 0 and set underrun.
    do_reset();
    fill_ram(16'hFFFF);
    div       = 4;
    ack_delay = 40;
    req_log.delete();
    pix(0, 200, 1'b1);
    pix(64, 200, 1'b0);
    check_val("starve_pixel_x64", o_pixel, 0);
    check_val("starve_underrun", o_underrun, 1);
    for (int x = 65; x < 575; x++) pix(x, 200, 1'b0);
    pix(575, 200, 1'b1);
    for (int x = 576; x < 800; x++) pix(x, 200, 1'b1);
    check_val("starve_req_count", req_log.size(), 32);
    div       = 1;
    ack_delay = 1;

    // Line start with a read outstanding: the stale word must be dropped.
    do_reset();
    fill_ram(16'h0000);
    ram[88 * 32] = 16'hFFFF;
    for (int k = 0; k < 32; k++) ram[89 * 32 + k] = 16'hA5C3 ^ 16'(k);
    ack_delay = 20;
    for (int x = 0; x < 10; x++) pix(x, 200, 1'b1);
    check_val("pend_req_before", o_rd_req, 1);
    pix(0, 201, 1'b1);
    req_log.delete();
    check_val("pend_req_held", o_rd_req, 1);
    ack_delay = 1;
    for (int x = 1; x < 800; x++) pix(x, 201, 1'b1);
    check_val("newline_first_addr", first_req(), 89 * 32);
    check_val("newline_req_count", req_log.size(), 32);
    check_val("newline_underrun", o_underrun, 0);

    // Reset mid-line with a read outstanding and sticky underrun set.
    do_reset();
    fill_ram(16'h0000);
    for (int k = 0; k < 32; k++) ram[48 * 32 + k] = 16'h3C5A + 16'(k * 7);
    ack_delay = 50;
    pix(0, 150, 1'b1);
    for (int x = 64; x < 71; x++) pix(x, 150, 1'b0);
    pix(700, 491, 1'b1);
    check_val("prerst_rd_req", o_rd_req, 1);
    check_val("prerst_underrun", o_underrun, 1);
    check_val("prerst_hs", o_hs, 0);
    check_val("prerst_vs", o_vs, 0);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_val("midrst_rd_req", o_rd_req, 0);
    check_val("midrst_hs", o_hs, 1);
    check_val("midrst_vs", o_vs, 1);
    check_val("midrst_underrun", o_underrun, 0);
    check_val("midrst_pixel", o_pixel, 0);
    ack_delay = 1;
    repeat (60) @(negedge clk);
    check_val("postrst_rd_req_idle", o_rd_req, 0);
    line(160);
    check_val("postrst_first_addr", first_req(), 48 * 32);
    check_val("postrst_req_count", req_log.size(), 32);
    check_val("postrst_underrun", o_underrun, 0);

    // Whole frame, sampled around every sync edge on every line.
    do_reset();
    for (int y = 0; y < 525; y++) begin
      pix(0, y, 1'b1);
      pix(1, y, 1'b1);
      pix(655, y, 1'b1);
      pix(656, y, 1'b1);
      pix(657, y, 1'b1);
      pix(751, y, 1'b1);
      pix(752, y, 1'b1);
      pix(799, y, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
